// File: rtl/poly_voice_alloc_pkg.sv
// Shared widths and encodings for the polyphonic voice allocator.
package poly_voice_alloc_pkg;

  localparam int unsigned NOTE_W = 7;
  localparam int unsigned VEL_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef enum logic {
    EV_ON  = 1'b0,
    EV_OFF = 1'b1
  } ev_t;

  typedef struct packed {
    logic [NOTE_W-1:0] num;
    logic [VEL_W-1:0]  vel;
    ev_t               ev;
  } event_t;

endpackage

// File: rtl/poly_voice_alloc_if.sv
// Note-event input and voice-bank output bundle of the allocator.
interface poly_voice_alloc_if #(
  parameter int unsigned VOICES = 4
);
  import poly_voice_alloc_pkg::*;

  localparam int unsigned CNT_W = $clog2(VOICES + 1);

  logic [NOTE_W-1:0]        note_num;
  logic [VEL_W-1:0]         note_vel;
  logic                     note_on;
  logic                     note_off;
  logic [NOTE_W*VOICES-1:0] note_num_all;
  logic [VEL_W*VOICES-1:0]  note_vel_all;
  logic [VOICES-1:0]        gate;
  logic [VOICES-1:0]        trig;
  logic                     stolen;
  logic                     dropped;
  logic                     busy;
  logic [CNT_W-1:0]         active_cnt;

  modport master (
    output note_num, note_vel, note_on, note_off,
    input  note_num_all, note_vel_all, gate, trig, stolen, dropped, busy, active_cnt
  );

  modport slave (
    input  note_num, note_vel, note_on, note_off,
    output note_num_all, note_vel_all, gate, trig, stolen, dropped, busy, active_cnt
  );

endinterface

// File: rtl/poly_voice_alloc_voice_slot.sv
// One voice slot: held note/velocity, gate and saturating age.
module poly_voice_alloc_voice_slot
  import poly_voice_alloc_pkg::*;
#(
  parameter int unsigned AGE_W = 4
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              clear,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [VEL_W-1:0]  vel_in,
  output logic [NOTE_W-1:0] note,
  output logic [VEL_W-1:0]  vel,
  output logic              gate,
  output logic [AGE_W-1:0]  age
);

  // Release keeps note/vel so the envelope can finish its tail.
  always_ff @(posedge clk) begin
    if (clear) begin
      note <= '0;
      vel  <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (ce) begin
      if (load) begin
        note <= note_in;
        vel  <= vel_in;
        gate <= 1'b1;
        age  <= '0;
      end else begin
        if (rel) gate <= 1'b0;
        if (age_inc && (age != '1)) age <= age + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/poly_voice_alloc.sv
// Assigns note events to voice slots: retrigger, free-voice pick, oldest-voice steal.
module poly_voice_alloc
  import poly_voice_alloc_pkg::*;
#(
  parameter int unsigned VOICES = 4,
  parameter int unsigned AGE_W  = 4,
  parameter bit          STEAL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  poly_voice_alloc_if.slave bus
);

  localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned CNT_W = $clog2(VOICES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

  state_t            state_q, state_d;
  event_t            ev_q, ev_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              match_found_q, match_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              old_found_q, old_found_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;
  logic [VOICES-1:0] trig_q, trig_d;
  logic              stolen_q, stolen_d;
  logic              dropped_q, dropped_d;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  tgt;
  logic              tgt_valid;
  logic [VOICES-1:0] load, rel, age_inc;
  logic              evt_req;

  logic [NOTE_W-1:0] v_note [VOICES];
  logic [VEL_W-1:0]  v_vel  [VOICES];
  logic [AGE_W-1:0]  v_age  [VOICES];
  logic [VOICES-1:0] v_gate;

  for (genvar i = 0; i < VOICES; i++) begin : g_voice
    poly_voice_alloc_voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk     (clk),
      .ce      (ce),
      .clear   (rst),
      .load    (load[i]),
      .rel     (rel[i]),
      .age_inc (age_inc[i]),
      .note_in (ev_q.num),
      .vel_in  (ev_q.vel),
      .note    (v_note[i]),
      .vel     (v_vel[i]),
      .gate    (v_gate[i]),
      .age     (v_age[i])
    );
    assign bus.note_num_all[NOTE_W*i +: NOTE_W] = v_note[i];
    assign bus.note_vel_all[VEL_W*i +: VEL_W]   = v_vel[i];
  end

  assign evt_req = bus.note_on | bus.note_off;

  // Next-state, scan bookkeeping and commit decisions.
  always_comb begin
    state_d       = state_q;
    ev_d          = ev_q;
    idx_d         = idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    trig_d        = '0;
    stolen_d      = 1'b0;
    dropped_d     = 1'b0;
    cnt_d         = cnt_q;
    tgt           = '0;
    tgt_valid     = 1'b0;
    rel           = '0;
    load          = '0;
    age_inc       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (evt_req) begin
          ev_d.num      = bus.note_num;
          ev_d.vel      = bus.note_vel;
          ev_d.ev       = (bus.note_on && (bus.note_vel != '0)) ? EV_ON : EV_OFF;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          state_d       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (v_gate[idx_q] && (v_note[idx_q] == ev_q.num) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!v_gate[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (v_gate[idx_q] && (!old_found_q || (v_age[idx_q] > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = v_age[idx_q];
        end
        if (idx_q == LAST_IDX) state_d = ST_COMMIT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (ev_q.ev == EV_ON) begin
          if (match_found_q) begin
            tgt       = match_idx_q;
            tgt_valid = 1'b1;
          end else if (free_found_q) begin
            tgt       = free_idx_q;
            tgt_valid = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end else if (STEAL && old_found_q) begin
            tgt       = old_idx_q;
            tgt_valid = 1'b1;
            stolen_d  = 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end else if (match_found_q) begin
          for (int i = 0; i < VOICES; i++) rel[i] = (match_idx_q == IDX_W'(i));
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < VOICES; i++) begin
      load[i]    = tgt_valid && (tgt == IDX_W'(i));
      age_inc[i] = tgt_valid && v_gate[i] && (tgt != IDX_W'(i));
    end
    trig_d = load;

    if ((state_q != ST_IDLE) && evt_req) dropped_d = 1'b1;
  end

  // State register; pulse registers clear on any edge without CE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ev_q          <= '0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      trig_q        <= '0;
      stolen_q      <= 1'b0;
      dropped_q     <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (ce) begin
        state_q       <= state_d;
        ev_q          <= ev_d;
        idx_q         <= idx_d;
        match_found_q <= match_found_d;
        match_idx_q   <= match_idx_d;
        free_found_q  <= free_found_d;
        free_idx_q    <= free_idx_d;
        old_found_q   <= old_found_d;
        old_idx_q     <= old_idx_d;
        old_age_q     <= old_age_d;
        busy_q        <= (state_d != ST_IDLE);
        cnt_q         <= cnt_d;
      end
      trig_q    <= ce ? trig_d    : '0;
      stolen_q  <= ce ? stolen_d  : 1'b0;
      dropped_q <= ce ? dropped_d : 1'b0;
    end
  end

  assign bus.gate       = v_gate;
  assign bus.trig       = trig_q & {VOICES{ce}};
  assign bus.stolen     = stolen_q & ce;
  assign bus.dropped    = dropped_q & ce;
  assign bus.busy       = busy_q;
  assign bus.active_cnt = cnt_q;

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Directed scoreboard bench for poly_voice_alloc (4 voices, stealing and non-stealing).
module tb_poly_voice_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  always #5 clk = ~clk;

  poly_voice_alloc_if #(.VOICES(4)) bus1 ();
  poly_voice_alloc_if #(.VOICES(4)) bus0 ();

  poly_voice_alloc #(.VOICES(4), .AGE_W(4), .STEAL(1'b1)) dut1 (
    .clk (clk), .rst (rst), .ce (ce), .bus (bus1)
  );
  poly_voice_alloc #(.VOICES(4), .AGE_W(4), .STEAL(1'b0)) dut0 (
    .clk (clk), .rst (rst), .ce (ce), .bus (bus0)
  );

  typedef struct packed {
    logic [27:0] num;
    logic [27:0] vel;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic        stolen;
    logic        dropped;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  int m_note [4];
  int m_vel  [4];
  int m_age  [4];
  bit m_gate [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 1'b0;
    end
  endtask

  // Behavioural reference for the stealing instance; pushes the expected commit result.
  task automatic model_event(input int num, input int vel, input bit on, input bit off);
    exp_t e;
    int   tgt;
    int   n;
    bit   is_on;
    e     = '0;
    tgt   = -1;
    is_on = on && (vel != 0);
    if (is_on) begin
      for (int i = 0; i < 4; i++) if (tgt < 0 && m_gate[i] && m_note[i] == num) tgt = i;
      if (tgt < 0) for (int i = 0; i < 4; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin
        for (int i = 0; i < 4; i++) if (tgt < 0 || m_age[i] > m_age[tgt]) tgt = i;
        e.stolen = 1'b1;
      end
      for (int i = 0; i < 4; i++)
        if (i != tgt && m_gate[i] && m_age[i] < 15) m_age[i]++;
      m_note[tgt] = num; m_vel[tgt] = vel; m_gate[tgt] = 1'b1; m_age[tgt] = 0;
      e.trig[tgt] = 1'b1;
    end else if (on || off) begin
      for (int i = 0; i < 4; i++) if (tgt < 0 && m_gate[i] && m_note[i] == num) tgt = i;
      if (tgt >= 0) m_gate[tgt] = 1'b0;
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      e.num[7*i +: 7] = 7'(m_note[i]);
      e.vel[7*i +: 7] = 7'(m_vel[i]);
      e.gate[i]       = m_gate[i];
      if (m_gate[i]) n++;
    end
    e.cnt = 3'(n);
    sb.push_back(e);
  endtask

  task automatic drive(input int num, input int vel, input bit on, input bit off);
    bus1.note_num = 7'(num); bus1.note_vel = 7'(vel); bus1.note_on = on; bus1.note_off = off;
    bus0.note_num = 7'(num); bus0.note_vel = 7'(vel); bus0.note_on = on; bus0.note_off = off;
  endtask

  // Drive one event, optionally pausing CE or poking a second event mid-scan, then score the commit.
  task automatic run_event(input int num, input int vel, input bit on, input bit off,
                           input bit gap, input bit poke);
    exp_t e;
    int   cyc;
    model_event(num, vel, on, off);
    @(negedge clk);
    drive(num, vel, on, off);
    @(posedge clk);
    #1;
    check("busy_rise", 64'(bus1.busy), 64'(1));
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      drive(0, 0, 1'b0, 1'b0);
      ce = !(gap && cyc >= 1 && cyc <= 3);
      if (poke && cyc == 2) drive(99, 99, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 3) check("busy_drop", 64'(bus1.dropped), 64'(1));
      if (!bus1.busy) break;
    end
    check("latency", 64'(cyc), gap ? 64'(8) : 64'(5));
    e = sb.pop_front();
    check("note_all", 64'(bus1.note_num_all), 64'(e.num));
    check("vel_all",  64'(bus1.note_vel_all), 64'(e.vel));
    check("gate",     64'(bus1.gate),         64'(e.gate));
    check("trig",     64'(bus1.trig),         64'(e.trig));
    check("stolen",   64'(bus1.stolen),       64'(e.stolen));
    check("dropped",  64'(bus1.dropped),      64'(e.dropped));
    check("cnt",      64'(bus1.active_cnt),   64'(e.cnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [27:0] n0;
    drive(0, 0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_note", 64'(bus1.note_num_all), 64'(0));
    check("rst_gate", 64'(bus1.gate),         64'(0));
    check("rst_busy", 64'(bus1.busy),         64'(0));
    check("rst_cnt",  64'(bus1.active_cnt),   64'(0));
    check("rst_trig", 64'(bus1.trig),         64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Fill all four voices.
    run_event(10, 127, 1'b1, 1'b0, 1'b0, 1'b0);
    run_event(11, 127, 1'b1, 1'b0, 1'b0, 1'b0);
    run_event(12, 127, 1'b1, 1'b0, 1'b0, 1'b0);
    run_event(13, 127, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full: stealing instance takes voice 0, non-stealing instance drops.
    run_event(15, 127, 1'b1, 1'b0, 1'b0, 1'b0);
    n0 = {7'd13, 7'd12, 7'd11, 7'd10};
    check("s0_note",    64'(bus0.note_num_all), 64'(n0));
    check("s0_dropped", 64'(bus0.dropped),      64'(1));
    check("s0_stolen",  64'(bus0.stolen),       64'(0));
    check("s0_trig",    64'(bus0.trig),         64'(0));
    check("s0_gate",    64'(bus0.gate),         64'(4'b1111));

    // Note-off, refill, retrigger, velocity-0 off, absent off.
    run_event(11, 0,   1'b0, 1'b1, 1'b0, 1'b0);
    run_event(14, 100, 1'b1, 1'b0, 1'b0, 1'b0);
    run_event(12, 64,  1'b1, 1'b0, 1'b0, 1'b0);
    run_event(13, 0,   1'b1, 1'b0, 1'b0, 1'b0);
    run_event(50, 10,  1'b0, 1'b1, 1'b0, 1'b0);

    // Event while busy, then age-driven steals, one with a CE pause and both pulses set.
    run_event(20, 100, 1'b1, 1'b0, 1'b0, 1'b1);
    run_event(21, 90,  1'b1, 1'b1, 1'b0, 1'b0);
    run_event(22, 80,  1'b1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a scan.
    @(negedge clk);
    drive(40, 90, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_note", 64'(bus1.note_num_all), 64'(0));
    check("mid_rst_vel",  64'(bus1.note_vel_all), 64'(0));
    check("mid_rst_gate", 64'(bus1.gate),         64'(0));
    check("mid_rst_busy", 64'(bus1.busy),         64'(0));
    check("mid_rst_cnt",  64'(bus1.active_cnt),   64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    run_event(30, 70, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ce = 1'b0;
    #1;
    check("ce_gate_trig", 64'(bus1.trig), 64'(0));
    @(negedge clk);
    ce = 1'b1;
    #1;
    check("trig_cleared", 64'(bus1.trig), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
